irq_controller: RTL
===================

IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 The block SHALL use the ports below; reset i_RSTn, synchronous, active-low; clock i_CLK.
REQ-002 i_CLK  in  1  core clock, all state on rising edge.
REQ-003 i_RSTn  in  1  synchronous active-low reset.
REQ-004 i_IRQ_SRC  in  8  asynchronous interrupt lines, level-high, bit 0 highest priority.
REQ-005 i_EN  in  1  decode-stage advance enable, same signal that feeds decode.
REQ-006 i_MODE  in  1  decode privilege mode, 0 = USER, 1 = MACHINE.
REQ-007 i_PC  in  32  decode program counter.
REQ-008 i_CFG_WE  in  1  config write strobe.
REQ-009 i_CFG_ADDR  in  2  config register select: 0 ENABLE, 1 BASE, 2 PENDING (W1C), 3 CAUSE (read-only).
REQ-010 i_CFG_WDATA  in  32  config write data.
REQ-011 o_CFG_RDATA  out  32  registered read data of register at i_CFG_ADDR, 1-cycle latency.
REQ-012 o_IRQ  out  1  registered trap request to decode.
REQ-013 o_HANDLER_BASE  out  32  vector = {BASE[31:7], cause[2:0], 4'b0000}.
REQ-014 o_MEPC  out  32  PC captured at trap acceptance.
REQ-015 o_CAUSE  out  3  index of the interrupt being requested or serviced.
REQ-016 o_BUSY  out  1  high in any state other than IDLE.

Function
REQ-017 Each i_IRQ_SRC bit SHALL pass a 2-flop synchronizer; a rising edge on the synchronized bit SHALL set PENDING[i] on the next edge.
REQ-018 Config write to PENDING SHALL clear bits written 1; a simultaneous rising edge on the same bit SHALL win (bit stays set).
REQ-019 Writes to ENABLE (bits 7:0 used) and BASE (bits 31:7 stored, 6:0 read 0) SHALL take effect the following cycle; writes to CAUSE SHALL be ignored.
REQ-020 FSM states: IDLE, REQ, ACCEPTED, ACTIVE.
REQ-021 IDLE: if (PENDING & ENABLE) != 0 -> REQ; cause <= lowest set index; o_IRQ <= 1.
REQ-022 REQ: accept = o_IRQ & i_EN & (i_MODE == 0); on accept: o_MEPC <= i_PC, PENDING[cause] <= 0, o_IRQ <= 0 -> ACCEPTED.
REQ-023 REQ: without accept, if ENABLE[cause] == 0 or PENDING[cause] == 0 -> IDLE, o_IRQ <= 0 (withdraw); accept SHALL take priority over withdraw in the same cycle.
REQ-024 REQ: cause SHALL remain frozen; a higher-priority source arriving later SHALL NOT preempt it.
REQ-025 ACCEPTED: i_MODE == 1 -> ACTIVE; otherwise hold.
REQ-026 ACTIVE: i_MODE == 0 (mret completed) -> IDLE; o_IRQ SHALL stay 0; new pendings SHALL accumulate.
REQ-027 o_IRQ SHALL be high only in REQ; with i_EN low, o_IRQ and all state SHALL hold.
REQ-028 o_HANDLER_BASE and o_CAUSE SHALL be stable from REQ entry through ACTIVE exit.
REQ-029 Minimum IDLE-to-o_IRQ latency: 1 cycle after PENDING & ENABLE becomes non-zero; source-edge to o_IRQ: 4 cycles.

Reset
REQ-030 On i_RSTn == 0 at a clock edge: state IDLE, o_IRQ 0, PENDING 0, ENABLE 0, BASE 0x0000_0100, cause 0, o_MEPC 0, o_CFG_RDATA 0, synchronizers 0, o_BUSY 0.
REQ-031 Reset mid-operation (any state) SHALL return to the REQ-030 values on the next edge with no residual request.

Verification
REQ-032 ENABLE=0x04, pulse i_IRQ_SRC[2], i_EN=1, i_MODE=0, i_PC=0x40 -> o_IRQ 1 four cycles after edge, o_HANDLER_BASE 0x120, after accept o_MEPC 0x40, PENDING[2]=0.
REQ-033 ENABLE=0xFF, raise bits 5 and 1 same cycle -> o_CAUSE 1, o_HANDLER_BASE 0x110; after mret (i_MODE 0->1->0) second request o_CAUSE 5, 0x150.
REQ-034 In REQ with i_EN=0 for 3 cycles -> o_IRQ held 1, o_MEPC unchanged; then i_EN=1 -> accept, o_IRQ 0 next cycle.
REQ-035 In REQ, write ENABLE=0x00 with no accept -> o_IRQ 0 next cycle, state IDLE, PENDING bit still set; re-enable -> o_IRQ 1 again.
REQ-036 PENDING W1C of bit 3 coincident with new edge on bit 3 -> PENDING[3] remains 1; W1C alone -> 0.
REQ-037 Assert i_RSTn=0 in ACTIVE -> all outputs at REQ-030 values next cycle, o_BUSY 0, o_CFG_RDATA for BASE reads 0x100.

Source files
------------

// File: rtl/irq_controller.sv
// Eight-source interrupt controller: synchronises level-high lines into a pending set and
// hands one priority-ordered trap request at a time to the decode stage.
module irq_controller (
  input  logic        i_CLK,
  input  logic        i_RSTn,
  input  logic [7:0]  i_IRQ_SRC,
  input  logic        i_EN,
  input  logic        i_MODE,
  input  logic [31:0] i_PC,
  input  logic        i_CFG_WE,
  input  logic [1:0]  i_CFG_ADDR,
  input  logic [31:0] i_CFG_WDATA,
  output logic [31:0] o_CFG_RDATA,
  output logic        o_IRQ,
  output logic [31:0] o_HANDLER_BASE,
  output logic [31:0] o_MEPC,
  output logic [2:0]  o_CAUSE,
  output logic        o_BUSY
);
  typedef enum logic [1:0] {IDLE, REQ, ACCEPTED, ACTIVE} state_e;

  localparam logic [1:0]  ADDR_ENABLE  = 2'd0;
  localparam logic [1:0]  ADDR_BASE    = 2'd1;
  localparam logic [1:0]  ADDR_PENDING = 2'd2;
  localparam logic [31:7] BASE_RESET   = 25'h000_0002; // 0x0000_0100

  logic [7:0]  sync1_q, sync2_q, sync_prev_q;
  logic [7:0]  pending_q, pending_d;
  logic [7:0]  enable_q;
  logic [31:7] base_q;
  logic [31:0] cfg_rdata_q, cfg_rdata_d;

  state_e      state_q;
  logic        irq_q;
  logic [2:0]  cause_q;
  logic [31:0] mepc_q;
  logic [31:0] handler_q;

  logic [7:0]  rise, active_mask, w1c_mask, accept_clr;
  logic [2:0]  first_idx;
  logic        accept, withdraw;

  // NOTE: every flop uses non-blocking (<=) so all registers sample pre-edge values.
  always_ff @(posedge i_CLK) begin
    if (!i_RSTn) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      sync_prev_q <= '0;
    end else begin
      sync1_q     <= i_IRQ_SRC;
      sync2_q     <= sync1_q;
      sync_prev_q <= sync2_q;
    end
  end

  assign rise        = sync2_q & ~sync_prev_q;
  assign active_mask = pending_q & enable_q;

  // NOTE: default assigned before the loop so this stays purely combinational (no latch).
  always_comb begin
    first_idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (active_mask[i]) first_idx = 3'(i);
    end
  end

  assign accept     = (state_q == REQ) && irq_q && i_EN && !i_MODE;
  assign withdraw   = (state_q == REQ) && !(enable_q[cause_q] && pending_q[cause_q]);
  assign accept_clr = accept ? (8'd1 << cause_q) : 8'd0;
  assign w1c_mask   = (i_CFG_WE && i_CFG_ADDR == ADDR_PENDING) ? i_CFG_WDATA[7:0] : 8'd0;

  // A fresh edge beats both software W1C and the acceptance clear on the same bit.
  assign pending_d  = (pending_q & ~w1c_mask & ~accept_clr) | rise;

  always_comb begin
    cfg_rdata_d = '0;
    case (i_CFG_ADDR)
      ADDR_ENABLE:  cfg_rdata_d = {24'd0, enable_q};
      ADDR_BASE:    cfg_rdata_d = {base_q, 7'd0};
      ADDR_PENDING: cfg_rdata_d = {24'd0, pending_q};
      default:      cfg_rdata_d = {29'd0, cause_q};
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (!i_RSTn) begin
      pending_q   <= '0;
      enable_q    <= '0;
      base_q      <= BASE_RESET;
      cfg_rdata_q <= '0;
    end else begin
      pending_q   <= pending_d;
      cfg_rdata_q <= cfg_rdata_d;
      if (i_CFG_WE && i_CFG_ADDR == ADDR_ENABLE) enable_q <= i_CFG_WDATA[7:0];
      if (i_CFG_WE && i_CFG_ADDR == ADDR_BASE)   base_q   <= i_CFG_WDATA[31:7];
    end
  end

  // The whole trap sequencer advances only with the decode stage; cause and vector
  // are latched on REQ entry and held until the handler returns.
  always_ff @(posedge i_CLK) begin
    if (!i_RSTn) begin
      state_q   <= IDLE;
      irq_q     <= 1'b0;
      cause_q   <= '0;
      mepc_q    <= '0;
      handler_q <= {BASE_RESET, 7'd0};
    end else if (i_EN) begin
      case (state_q)
        IDLE: begin
          if (|active_mask) begin
            state_q   <= REQ;
            irq_q     <= 1'b1;
            cause_q   <= first_idx;
            handler_q <= {base_q, first_idx, 4'd0};
          end
        end
        REQ: begin
          if (accept) begin
            mepc_q  <= i_PC;
            irq_q   <= 1'b0;
            state_q <= ACCEPTED;
          end else if (withdraw) begin
            irq_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        ACCEPTED: if (i_MODE)  state_q <= ACTIVE;
        ACTIVE:   if (!i_MODE) state_q <= IDLE;
        default: begin
          state_q <= IDLE;
          irq_q   <= 1'b0;
        end
      endcase
    end
  end

  assign o_CFG_RDATA    = cfg_rdata_q;
  assign o_IRQ          = irq_q;
  assign o_HANDLER_BASE = handler_q;
  assign o_MEPC         = mepc_q;
  assign o_CAUSE        = cause_q;
  assign o_BUSY         = (state_q != IDLE);
endmodule
